eeprom_serial_seq: RTL and testbench
====================================

Name: eeprom_serial_seq

Overview:
Command-level sequencer for the serial EEPROM/RTC on the CS4 address space. It accepts one READ/WRITE/ERASE/SPECIAL command at a time and generates eeprom_ce, eeprom_clock and eeprom_di, MSB-first, with a programmable bit rate. It samples eeprom_do for read data and for the write-complete (ready/busy) poll. It replaces per-bit CPU toggling of the EEPROM register, and the EEPROM pins are muxed with it.

Parameters:
CLK_DIV, 2, clock cycles per half-period of eeprom_clock (legal values ≥1)
ADDR_W, 6, EEPROM word-address width
DATA_W, 16, EEPROM word width
POLL_MAX, 65535, maximum clocks spent in POLL before timeout

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted on clock edge with cmd_valid&&cmd_ready
cmd_op  in  2  10=READ, 01=WRITE, 11=ERASE, 00=SPECIAL (EWEN/EWDS/ERAL/WRAL selected by cmd_addr[ADDR_W-1:ADDR_W-2])
cmd_addr  in  ADDR_W  word address / special sub-op
cmd_wdata  in  DATA_W  write data (WRITE, SPECIAL-WRAL)
rsp_valid  out  1  one-cycle pulse: command finished
rsp_rdata  out  DATA_W  read word; valid with rsp_valid, held until next accept
rsp_err  out  1  valid with rsp_valid: poll timeout (or verify mismatch, see option)
busy  out  1  high when not IDLE
eeprom_ce  out  1  chip enable, active high
eeprom_clock  out  1  serial clock
eeprom_di  out  1  serial data to device
eeprom_do  in  1  serial data from device (synchronous to clock domain by caller)

Behaviour:
- Reset values: cmd_ready=0 during reset then 1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, eeprom_ce=0, eeprom_clock=0, eeprom_di=0. A reset mid-command aborts immediately: pins go to reset values on the next edge, no rsp_valid is issued.
- Inputs are latched at acceptance; later changes are ignored.
- Half-period counter: tick every CLK_DIV clocks. Bit = low phase (DI updated at start, clock=0) then high phase (clock=1), CLK_DIV clocks each.
- Command frame: N_CMD = 3+ADDR_W bits = start bit 1, cmd_op[1:0], cmd_addr MSB-first.
- States:
  - IDLE
  - SETUP: CE=1, clock=0, DI=0 for CLK_DIV clocks
  - SH_CMD: N_CMD bits
  - SH_DATA: DATA_W bits; only for WRITE, WRAL, READ
  - DESEL: CE=0, clock=0, DI=0 for 2*CLK_DIV clocks
  - POLL
  - DESEL2: same as DESEL
  - DONE: rsp_valid for 1 clock, then IDLE
- Transitions:
  - READ/EWEN/EWDS: SH_CMD → SH_DATA (READ only) → DESEL → DONE.
  - WRITE/ERASE/ERAL/WRAL: SH_CMD → SH_DATA (WRITE/WRAL only) → DESEL → POLL → DESEL2 → DONE.
- READ: DI=0 during SH_DATA. eeprom_do is sampled on the clock cycle where eeprom_clock falls, shifted in MSB-first. rsp_rdata is updated at DONE.
- POLL: CE=1, clock=0. eeprom_do is sampled every clock; the first 1 → DESEL2 with rsp_err=0. Counter reaches POLL_MAX without DO=1 → DESEL2 with rsp_err=1.
- Latency with CLK_DIV=2, ADDR_W=6, DATA_W=16, counting the accept edge as cycle 0:
  - READ: rsp_valid at cycle 106.
  - EWEN: rsp_valid at cycle 42.
- cmd_valid during busy: ignored and held off (cmd_ready=0). A new command can be accepted the cycle after rsp_valid.

Optional Feature:
EEPROM_SEQ_VERIFY_EN:
- Defined: after a successful WRITE poll, DESEL2 is followed by an automatic READ of the same address (SETUP … DESEL). rsp_err=1 if the read word ≠ cmd_wdata; rsp_rdata returns the read-back word; rsp_valid is issued only after verify. Timeout still skips verify and sets rsp_err=1.
- Undefined: no verify. WRITE rsp_rdata keeps its previous value.

Test Plan:
- Reset mid-READ at cycle 30 → next edge ce=0, clock=0, di=0, busy=0; no rsp_valid.
- READ addr 6'h15, model drives 16'hA5C3 → DI frame 1,1,0,0,1,0,1,0,1; rsp_valid at cycle 106, rsp_rdata=16'hA5C3, rsp_err=0.
- WRITE addr 6'h3F data 16'h1234, model DO=0 for 50 poll clocks then 1 → data bits 0001001000110100 on DI, single rsp_valid, rsp_err=0, CE low ≥4 clocks both sides of POLL.
- WRITE, model never raises DO, POLL_MAX=100 → rsp_err=1 exactly 100 POLL clocks after POLL entry (+DESEL2+1).
- EWEN (op 00, addr 6'h30) back-to-back with READ held valid → EWEN rsp_valid at 42, READ accepted cycle 43, cmd_ready low throughout.
- With EEPROM_SEQ_VERIFY_EN, WRITE 16'hBEEF, model stores 16'hBEEE → rsp_err=1, rsp_rdata=16'hBEEE.

Source files
------------

// File: rtl/eeprom_serial_seq.sv
// eeprom_serial_seq: command-level sequencer for the serial EEPROM/RTC.
// Each accepted command becomes a chip-select frame: a start bit, the 2-bit
// opcode and the address, all MSB first. READ, WRITE and WRAL then shift a
// data word. Writes and erases finish with a deselect gap and a ready/busy
// poll on eeprom_do.
// Optional build macro: EEPROM_SEQ_VERIFY_EN. When it is defined, a
// successful WRITE is followed by a read-back of the same address.
//
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only while idle, and it rises in
// the same cycle as the one-cycle rsp_valid pulse. This lets a command that
// is held valid be taken on the very next edge. rsp_rdata and rsp_err are
// valid with rsp_valid. rsp_rdata holds its value until the next READ
// completes.
module eeprom_serial_seq #(
  parameter int CLK_DIV  = 2,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int POLL_MAX = 65535
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              eeprom_ce,
  output logic              eeprom_clock,
  output logic              eeprom_di,
  input  logic              eeprom_do
);

  localparam int N_CMD = 3 + ADDR_W;
  localparam int NB    = (N_CMD > DATA_W) ? N_CMD : DATA_W;
  localparam int BW    = $clog2(NB + 1);
  localparam int DW    = $clog2(2 * CLK_DIV + 1);
  localparam int PW    = $clog2(POLL_MAX + 1);

  localparam logic [1:0] OP_SPECIAL = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_ERASE   = 2'b11;
  localparam logic [1:0] SUB_WRAL   = 2'b01;
  localparam logic [1:0] SUB_ERAL   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SH_CMD, S_SH_DATA, S_DESEL, S_POLL, S_DESEL2
  } state_t;

  state_t            state;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [PW-1:0]     poll_cnt;
  logic [1:0]        op_q;
  logic [1:0]        sub_q;
  logic [N_CMD-1:0]  cmd_sr;
  logic [DATA_W-1:0] wr_sr;
  logic [DATA_W-1:0] rd_sr;
  logic [DATA_W-1:0] wdata_q;
  logic              poll_err;
  logic              vfy;
`ifdef EEPROM_SEQ_VERIFY_EN
  logic [ADDR_W-1:0] addr_q;
`endif

  logic is_read, has_data, needs_poll, half_done, desel_done;

  // Decode the latched command and the divider terminal counts.
  always_comb begin
    is_read    = (op_q == OP_READ);
    has_data   = is_read || (op_q == OP_WRITE) ||
                 ((op_q == OP_SPECIAL) && (sub_q == SUB_WRAL));
    needs_poll = (op_q == OP_WRITE) || (op_q == OP_ERASE) ||
                 ((op_q == OP_SPECIAL) && ((sub_q == SUB_WRAL) || (sub_q == SUB_ERAL)));
    half_done  = (div_cnt == DW'(CLK_DIV - 1));
    desel_done = (div_cnt == DW'(2 * CLK_DIV - 1));
  end

  // Sequencer FSM. All pins and response outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      eeprom_ce    <= 1'b0;
      eeprom_clock <= 1'b0;
      eeprom_di    <= 1'b0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      poll_cnt     <= '0;
      op_q         <= '0;
      sub_q        <= '0;
      cmd_sr       <= '0;
      wr_sr        <= '0;
      rd_sr        <= '0;
      wdata_q      <= '0;
      poll_err     <= 1'b0;
      vfy          <= 1'b0;
`ifdef EEPROM_SEQ_VERIFY_EN
      addr_q       <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            op_q         <= cmd_op;
            sub_q        <= cmd_addr[ADDR_W-1 -: 2];
            cmd_sr       <= {1'b1, cmd_op, cmd_addr};
            wr_sr        <= cmd_wdata;
            wdata_q      <= cmd_wdata;
            poll_err     <= 1'b0;
            vfy          <= 1'b0;
`ifdef EEPROM_SEQ_VERIFY_EN
            addr_q       <= cmd_addr;
`endif
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
            eeprom_ce    <= 1'b1;
            eeprom_clock <= 1'b0;
            eeprom_di    <= 1'b0;
            div_cnt      <= '0;
            state        <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (half_done) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            eeprom_di <= cmd_sr[N_CMD-1];
            cmd_sr    <= cmd_sr << 1;
            state     <= S_SH_CMD;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_SH_CMD: begin
          if (!half_done) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!eeprom_clock) begin
              eeprom_clock <= 1'b1;
            end else begin
              eeprom_clock <= 1'b0;
              if (bit_cnt == BW'(N_CMD - 1)) begin
                bit_cnt <= '0;
                if (has_data) begin
                  // A read drives DI low while the device talks back.
                  eeprom_di <= wr_sr[DATA_W-1] & ~is_read;
                  wr_sr     <= wr_sr << 1;
                  state     <= S_SH_DATA;
                end else begin
                  eeprom_ce <= 1'b0;
                  eeprom_di <= 1'b0;
                  state     <= S_DESEL;
                end
              end else begin
                bit_cnt   <= bit_cnt + 1'b1;
                eeprom_di <= cmd_sr[N_CMD-1];
                cmd_sr    <= cmd_sr << 1;
              end
            end
          end
        end
        S_SH_DATA: begin
          if (!half_done) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!eeprom_clock) begin
              eeprom_clock <= 1'b1;
            end else begin
              // Read data is captured on the edge that drops the serial clock.
              eeprom_clock <= 1'b0;
              if (is_read) rd_sr <= {rd_sr[DATA_W-2:0], eeprom_do};
              if (bit_cnt == BW'(DATA_W - 1)) begin
                bit_cnt   <= '0;
                eeprom_ce <= 1'b0;
                eeprom_di <= 1'b0;
                state     <= S_DESEL;
              end else begin
                bit_cnt   <= bit_cnt + 1'b1;
                eeprom_di <= wr_sr[DATA_W-1] & ~is_read;
                wr_sr     <= wr_sr << 1;
              end
            end
          end
        end
        S_DESEL: begin
          if (!desel_done) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (needs_poll) begin
              eeprom_ce <= 1'b1;
              poll_cnt  <= '0;
              state     <= S_POLL;
            end else begin
              state     <= S_IDLE;
              rsp_valid <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              if (is_read) rsp_rdata <= rd_sr;
              rsp_err   <= vfy && (rd_sr != wdata_q);
            end
          end
        end
        S_POLL: begin
          // The device reports ready by raising DO while selected.
          if (eeprom_do) begin
            poll_err  <= 1'b0;
            eeprom_ce <= 1'b0;
            div_cnt   <= '0;
            state     <= S_DESEL2;
          end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
            poll_err  <= 1'b1;
            eeprom_ce <= 1'b0;
            div_cnt   <= '0;
            state     <= S_DESEL2;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        S_DESEL2: begin
          if (!desel_done) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
`ifdef EEPROM_SEQ_VERIFY_EN
            if ((op_q == OP_WRITE) && !poll_err) begin
              op_q      <= OP_READ;
              vfy       <= 1'b1;
              cmd_sr    <= {1'b1, OP_READ, addr_q};
              eeprom_ce <= 1'b1;
              state     <= S_SETUP;
            end else
`endif
            begin
              state     <= S_IDLE;
              rsp_valid <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              rsp_err   <= poll_err;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_serial_seq.sv
// tb_eeprom_serial_seq: directed bench for eeprom_serial_seq with
// CLK_DIV=2, ADDR_W=6, DATA_W=16, POLL_MAX=100.
// Build with EEPROM_SEQ_VERIFY_EN defined to cover the write read-back.
module tb_eeprom_serial_seq;

  localparam int N_CMD = 9;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        eeprom_ce;
  logic        eeprom_clock;
  logic        eeprom_di;
  logic        eeprom_do;

  eeprom_serial_seq #(
    .CLK_DIV(2), .ADDR_W(6), .DATA_W(16), .POLL_MAX(100)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .eeprom_ce(eeprom_ce), .eeprom_clock(eeprom_clock),
    .eeprom_di(eeprom_di), .eeprom_do(eeprom_do)
  );

  // Clock and cycle counter: cyc equals n when sampled 1 time unit after edge n.
  int cyc = 0;
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  always @(posedge clock) cyc <= cyc + 1;

  // Device model: records DI at each serial clock rise and serves rd_word MSB first.
  int          rise_cnt = 0;
  int          base = 0;
  int          mk;
  logic [63:0] cap = '0;
  logic [15:0] rd_word = '0;
  logic        do_model = 1'b0;
  logic        poll_mode = 1'b0;
  logic        poll_do = 1'b0;
  assign eeprom_do = poll_mode ? poll_do : do_model;

  always @(posedge eeprom_clock) begin
    mk = rise_cnt - base;
    if (mk >= N_CMD && mk < N_CMD + 16) do_model = rd_word[N_CMD + 15 - mk];
    cap = {cap[62:0], eeprom_di};
    rise_cnt = rise_cnt + 1;
  end

  // Scoreboard.
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] addr,
                      input logic [15:0] wd, output int t);
    int n;
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 500) begin tick(); n++; end
    check("accept_ready", cmd_ready, 1);
    tick();
    t = cyc;
    cmd_valid = 1'b0;
    cmd_op = ~op; cmd_addr = ~addr; cmd_wdata = ~wd;
  endtask

  task automatic wait_ce(input logic lvl, output int n);
    n = 0;
    while (eeprom_ce !== lvl && n < 3000) begin tick(); n++; end
    check("ce_wait", eeprom_ce, lvl);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 3000) begin tick(); n++; end
    check("rsp_seen", rsp_valid, 1);
    if (exp_q.size() != 0) check("rsp_rdata", rsp_rdata, exp_q.pop_front());
  endtask

  task automatic pulse_check(input string tag);
    tick();
    check(tag, rsp_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t, e, n, hi;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) tick();
    check("rst_ctrl", {cmd_ready, busy, rsp_valid, rsp_err}, 0);
    check("rst_pins", {eeprom_ce, eeprom_clock, eeprom_di}, 0);
    check("rst_rdata", rsp_rdata, 0);
    reset = 1'b0;
    tick();
    check("ready_after_rst", cmd_ready, 1);

    // READ 0x15 returning A5C3.
    rd_word = 16'hA5C3; base = rise_cnt; exp_q.push_back(16'hA5C3);
    send(2'b10, 6'h15, 16'h0000, t);
    check("rd_busy", {busy, cmd_ready}, 2'b10);
    wait_rsp(n);
    check("rd_lat", cyc - t, 106);
    check("rd_err", rsp_err, 0);
    check("rd_cmd_bits", cap[24:16], 9'h195);
    check("rd_di_low", cap[15:0], 0);
    pulse_check("rd_pulse");

    // WRITE 0x3F = 1234, ready after 50 poll clocks.
    rd_word = 16'h1234; base = rise_cnt;
`ifdef EEPROM_SEQ_VERIFY_EN
    exp_q.push_back(16'h1234);
`else
    exp_q.push_back(16'hA5C3);
`endif
    send(2'b01, 6'h3F, 16'h1234, t);
    wait_ce(1'b0, n);
    check("wr_desel_at", cyc - t, 102);
    wait_ce(1'b1, n);
    check("wr_desel_len", n, 4);
    e = cyc; poll_mode = 1'b1; poll_do = 1'b0;
    check("wr_frame", cap[24:0], {9'h17F, 16'h1234});
    repeat (50) @(posedge clock);
    #1 poll_do = 1'b1;
    wait_ce(1'b0, n);
    check("wr_poll_len", cyc - e, 51);
    n = 0;
    while (!eeprom_ce && !rsp_valid && n < 20) begin tick(); n++; end
    check("wr_desel2_len", n, 4);
    poll_mode = 1'b0; base = rise_cnt;
    wait_rsp(n);
`ifndef EEPROM_SEQ_VERIFY_EN
    check("wr_rsp_at", cyc - e, 55);
`endif
    check("wr_err", rsp_err, 0);
    pulse_check("wr_pulse");

    // WRITE that never becomes ready: timeout after 100 poll clocks.
    base = rise_cnt;
`ifdef EEPROM_SEQ_VERIFY_EN
    exp_q.push_back(16'h1234);
`else
    exp_q.push_back(16'hA5C3);
`endif
    send(2'b01, 6'h02, 16'h5555, t);
    wait_ce(1'b0, n);
    wait_ce(1'b1, n);
    e = cyc; poll_mode = 1'b1; poll_do = 1'b0;
    wait_rsp(n);
    check("to_lat", cyc - e, 104);
    check("to_err", rsp_err, 1);
    poll_mode = 1'b0;
    pulse_check("to_pulse");

    // EWEN followed by a READ held valid the whole time.
    rd_word = 16'h0F0F;
    exp_q.push_back(rsp_rdata);
    send(2'b00, 6'h30, 16'h0000, t);
    cmd_op = 2'b10; cmd_addr = 6'h2A; cmd_wdata = 16'h0000; cmd_valid = 1'b1;
    n = 0; hi = 0;
    while (!rsp_valid && n < 200) begin
      if (cmd_ready) hi++;
      tick(); n++;
    end
    check("ew_ready_low", hi, 0);
    wait_rsp(n);
    check("ew_lat", cyc - t, 42);
    check("ew_err", rsp_err, 0);
    check("ew_frame", cap[8:0], 9'h130);
    check("ew_ready_at_rsp", cmd_ready, 1);
    base = rise_cnt; exp_q.push_back(16'h0F0F);
    tick();
    t = cyc; cmd_valid = 1'b0;
    check("rd2_taken", {busy, cmd_ready, rsp_valid}, 3'b100);
    wait_rsp(n);
    check("rd2_lat", cyc - t, 106);
    check("rd2_cmd_bits", cap[24:16], 9'h1AA);
    pulse_check("rd2_pulse");

    // Reset 30 cycles into a READ aborts with no response.
    base = rise_cnt;
    send(2'b10, 6'h01, 16'h0000, t);
    while (cyc - t < 30) tick();
    check("mid_active", eeprom_ce, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_pins", {eeprom_ce, eeprom_clock, eeprom_di}, 0);
    check("mid_rst_ctrl", {busy, cmd_ready, rsp_valid}, 0);
    check("mid_rst_rdata", rsp_rdata, 0);
    reset = 1'b0;
    hi = 0;
    repeat (150) begin
      tick();
      if (rsp_valid) hi++;
    end
    check("mid_no_rsp", hi, 0);
    check("mid_idle", {cmd_ready, busy, eeprom_ce}, 3'b100);

`ifdef EEPROM_SEQ_VERIFY_EN
    // Read-back differs from the written word.
    rd_word = 16'hBEEE; base = rise_cnt; exp_q.push_back(16'hBEEE);
    send(2'b01, 6'h07, 16'hBEEF, t);
    wait_ce(1'b0, n);
    wait_ce(1'b1, n);
    poll_mode = 1'b1; poll_do = 1'b1;
    wait_ce(1'b0, n);
    poll_mode = 1'b0; base = rise_cnt;
    wait_rsp(n);
    check("vf_err", rsp_err, 1);
    pulse_check("vf_pulse");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
